// File: rtl/alu_mdu_seq.sv
// Sequential execute-stage ALU with iterative unsigned multiply/divide.
// Latency: simple ops 1 cycle, MUL/MULHU/DIVU/REMU WIDTH+1 cycles (accept edge to out_valid).
// Backpressure: in_ready high only in IDLE; in_valid in any other state is dropped, never queued.
module alu_mdu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] ALUop1,
    input  logic [WIDTH-1:0] ALUop2,
    input  logic [3:0]       ALUctrl,
    output logic             out_valid,
    output logic [WIDTH-1:0] ALUResult,
    output logic             EQ,
    output logic             busy
);
    localparam int SHAMT_W = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_SLT   = 4'b0101;
    localparam logic [3:0] OP_SLTU  = 4'b0110;
    localparam logic [3:0] OP_SLL   = 4'b0111;
    localparam logic [3:0] OP_SRL   = 4'b1000;
    localparam logic [3:0] OP_SRA   = 4'b1001;
    localparam logic [3:0] OP_MUL   = 4'b1010;
    localparam logic [3:0] OP_MULHU = 4'b1011;
    localparam logic [3:0] OP_DIVU  = 4'b1100;
    localparam logic [3:0] OP_REMU  = 4'b1101;

    localparam logic [SHAMT_W:0] CNT_INIT = (SHAMT_W+1)'(WIDTH);
    localparam logic [SHAMT_W:0] CNT_ONE  = (SHAMT_W+1)'(1);

    logic [1:0]       state_q, state_d;
    logic [SHAMT_W:0] cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    // acc: product high half (MUL) or partial remainder (DIV)
    // lo : multiplier / product low half (MUL) or dividend / quotient (DIV)
    // opb: multiplicand (MUL) or divisor (DIV)
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             eq_pend_q, eq_pend_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             eq_q, eq_d;

    logic [WIDTH-1:0]   simple_res;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_borrow;
    logic [WIDTH-1:0]   div_rem_next;
    logic [WIDTH-1:0]   div_quot_next;
    logic [SHAMT_W-1:0] shamt;

    assign shamt     = ALUop2[SHAMT_W-1:0];
    assign in_ready  = (state_q == S_IDLE);
    assign busy      = ~in_ready;
    assign out_valid = (state_q == S_DONE);
    assign ALUResult = result_q;
    assign EQ        = eq_q;

    // Single-cycle result for the non-iterative ops, taken straight from the live operands
    always_comb begin
        simple_res = '0;
        case (ALUctrl)
            OP_ADD:  simple_res = ALUop1 + ALUop2;
            OP_SUB:  simple_res = ALUop1 - ALUop2;
            OP_AND:  simple_res = ALUop1 & ALUop2;
            OP_OR:   simple_res = ALUop1 | ALUop2;
            OP_XOR:  simple_res = ALUop1 ^ ALUop2;
            OP_SLT:  simple_res = {{(WIDTH-1){1'b0}}, ($signed(ALUop1) < $signed(ALUop2))};
            OP_SLTU: simple_res = {{(WIDTH-1){1'b0}}, (ALUop1 < ALUop2)};
            OP_SLL:  simple_res = ALUop1 << shamt;
            OP_SRL:  simple_res = ALUop1 >> shamt;
            OP_SRA:  simple_res = $unsigned($signed(ALUop1) >>> shamt);
            default: simple_res = '0;
        endcase
    end

    // One shift-add multiply step and one restoring-divide step on the shared work registers
    always_comb begin
        mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        mul_next = {mul_sum, lo_q[WIDTH-1:1]};

        div_shift     = {acc_q, lo_q[WIDTH-1]};
        div_diff      = div_shift - {1'b0, opb_q};
        div_borrow    = (div_shift < {1'b0, opb_q});
        div_rem_next  = div_borrow ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
        div_quot_next = {lo_q[WIDTH-2:0], ~div_borrow};
    end

    // Control FSM: accept in IDLE, iterate WIDTH steps, publish result on DONE entry
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        acc_d     = acc_q;
        lo_d      = lo_q;
        opb_d     = opb_q;
        eq_pend_d = eq_pend_q;
        result_d  = result_q;
        eq_d      = eq_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d      = ALUctrl;
                    eq_pend_d = (ALUop1 == ALUop2);
                    if (ALUctrl == OP_MUL || ALUctrl == OP_MULHU) begin
                        state_d = S_MUL;
                        cnt_d   = CNT_INIT;
                        acc_d   = '0;
                        lo_d    = ALUop1;
                        opb_d   = ALUop2;
                    end else if (ALUctrl == OP_DIVU || ALUctrl == OP_REMU) begin
                        state_d = S_DIV;
                        cnt_d   = CNT_INIT;
                        acc_d   = '0;
                        lo_d    = ALUop1;
                        opb_d   = ALUop2;
                    end else begin
                        state_d  = S_DONE;
                        result_d = simple_res;
                        eq_d     = (ALUop1 == ALUop2);
                    end
                end
            end
            S_MUL: begin
                acc_d = mul_next[2*WIDTH-1:WIDTH];
                lo_d  = mul_next[WIDTH-1:0];
                cnt_d = cnt_q - CNT_ONE;
                // The last step's outcome is registered in the same edge that enters DONE
                if (cnt_q == CNT_ONE) begin
                    state_d  = S_DONE;
                    result_d = (op_q == OP_MULHU) ? mul_next[2*WIDTH-1:WIDTH] : mul_next[WIDTH-1:0];
                    eq_d     = eq_pend_q;
                end
            end
            S_DIV: begin
                acc_d = div_rem_next;
                lo_d  = div_quot_next;
                cnt_d = cnt_q - CNT_ONE;
                // A zero divisor never borrows, so quotient fills with ones and remainder = dividend
                if (cnt_q == CNT_ONE) begin
                    state_d  = S_DONE;
                    result_d = (op_q == OP_REMU) ? div_rem_next : div_quot_next;
                    eq_d     = eq_pend_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            acc_q     <= '0;
            lo_q      <= '0;
            opb_q     <= '0;
            eq_pend_q <= 1'b0;
            result_q  <= '0;
            eq_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            lo_q      <= lo_d;
            opb_q     <= opb_d;
            eq_pend_q <= eq_pend_d;
            result_q  <= result_d;
            eq_q      <= eq_d;
        end
    end
endmodule
